// File: rtl/lvds_rx_deserializer.sv
// ---------------------------------------------------------------------------
// lvds_rx_deserializer
//
// Receive side of the 7:1 LVDS pixel link. The clock lane and four data
// lanes arrive as single-ended bits sampled once per clk_in (7x pixel rate).
// The block finds the word boundary from the clock-lane pattern 1100011,
// confirms it over LOCK_COUNT consecutive words, and then decodes each
// aligned set of lane words into RGB888 plus HS/VS/DE.
//
// Parameters
//   LOCK_COUNT  consecutive good clock words needed to declare lock (2..15)
//   ERR_LIMIT   consecutive bad clock words, while locked, that drop lock (1..15)
//
// Ports
//   clk_in       in   bit-rate clock (7x pixel rate)
//   reset        in   synchronous, active-high
//   rxin_ck      in   sampled clock-lane bit
//   rxin[3:0]    in   sampled data-lane bits, lane n on bit n
//   red/green/blue out 8-bit recovered colour
//   hsync/vsync/de out recovered control bits
//   pixel_valid  out  one-cycle strobe when new pixel outputs are presented
//   locked       out  alignment established
//   err_count    out  clock-lane mismatches while locked
//
// Build option
//   LVDS_RX_ERR_CNT_EN  when defined, err_count is a saturating count of
//                       locked-state clock-word mismatches, cleared only by
//                       reset. When undefined, err_count is tied to zero.
// ---------------------------------------------------------------------------
module lvds_rx_deserializer #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        rxin_ck,
  input  logic [3:0]  rxin,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pixel_valid,
  output logic        locked,
  output logic [15:0] err_count
);

  localparam logic [6:0] CLK_PAT    = 7'b1100011;
  localparam logic [3:0] LOCK_N     = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_N     = 4'(ERR_LIMIT);
  localparam logic [2:0] PHASE_LAST = 3'd6;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Lane words to pixel, packed as {de, vs, hs, b[7:0], g[7:0], r[7:0]}.
  // Lane 3 bit 6 carries a constant 0 on the wire and is not passed in.
  function automatic logic [26:0] decode_pixel(input logic [6:0] w0,
                                               input logic [6:0] w1,
                                               input logic [6:0] w2,
                                               input logic [5:0] w3);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = {w3[1:0], w0[5:0]};
    g = {w3[3:2], w1[4:0], w0[6]};
    b = {w3[5:4], w2[3:0], w1[6:5]};
    return {w2[6], w2[5], w2[4], b, g, r};
  endfunction

`ifdef LVDS_RX_ERR_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic [6:0]  sr_ck_p0;
  logic [6:0]  sr_ln_p0 [4];
  state_t      state;
  state_t      state_next;
  logic [2:0]  phase;
  logic [2:0]  phase_next;
  logic [3:0]  good_cnt;
  logic [3:0]  good_next;
  logic [3:0]  miss_cnt;
  logic        match;
  logic        boundary;
  logic        load_pix;
  logic        miss_evt;
  logic [26:0] pix_p1;
  logic        vld_p1;
  logic        unused_lane3_bit6;

  assign unused_lane3_bit6 = sr_ln_p0[3][6];

  // ---- stage p0: serial capture, newest bit in bit 0 ----
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sr_ck_p0 <= '0;
      for (int i = 0; i < 4; i++) sr_ln_p0[i] <= '0;
    end else begin
      sr_ck_p0 <= {sr_ck_p0[5:0], rxin_ck};
      for (int i = 0; i < 4; i++) sr_ln_p0[i] <= {sr_ln_p0[i][5:0], rxin[i]};
    end
  end

  assign match    = (sr_ck_p0 == CLK_PAT);
  assign boundary = (phase == 3'd0);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= HUNT;
      phase    <= 3'd0;
      good_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      good_cnt <= good_next;
    end
  end

  // In HUNT the phase is parked at 0 and every cycle is a candidate
  // boundary; a match restarts the phase so the next boundary is 7 later.
  always_comb begin
    state_next = state;
    phase_next = (phase == PHASE_LAST) ? 3'd0 : phase + 3'd1;
    good_next  = good_cnt;
    load_pix   = 1'b0;
    miss_evt   = 1'b0;
    unique case (state)
      HUNT: begin
        phase_next = 3'd0;
        if (match) begin
          phase_next = 3'd1;
          good_next  = 4'd1;
          state_next = VERIFY;
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (match) begin
            good_next = good_cnt + 4'd1;
            if (good_next == LOCK_N) state_next = LOCKED;
          end else begin
            state_next = HUNT;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (match) begin
            load_pix = 1'b1;
          end else begin
            miss_evt = 1'b1;
            if (miss_cnt + 4'd1 == MISS_N) state_next = HUNT;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // Miss counter only runs in LOCKED, so every lock starts with a clean count.
  always_ff @(posedge clk_in) begin
    if (reset || state != LOCKED) begin
      miss_cnt <= 4'd0;
    end else if (load_pix) begin
      miss_cnt <= 4'd0;
    end else if (miss_evt) begin
      miss_cnt <= miss_cnt + 4'd1;
    end
  end

  // ---- stage p1: decoded pixel register, holds across bad words ----
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pix_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= load_pix;
      if (load_pix) begin
        pix_p1 <= decode_pixel(sr_ln_p0[0], sr_ln_p0[1], sr_ln_p0[2],
                               sr_ln_p0[3][5:0]);
      end
    end
  end

  assign red         = pix_p1[7:0];
  assign green       = pix_p1[15:8];
  assign blue        = pix_p1[23:16];
  assign hsync       = pix_p1[24];
  assign vsync       = pix_p1[25];
  assign de          = pix_p1[26];
  assign pixel_valid = vld_p1;
  assign locked      = (state == LOCKED);

`ifdef LVDS_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Survives lock loss and relock; only reset clears it.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      err_cnt_q <= 16'h0000;
    end else if (miss_evt) begin
      err_cnt_q <= sat_inc16(err_cnt_q);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule
